// File: rtl/mux8_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux8_rr_arbiter
// Brief    : Round-robin arbiter and sequencer for an 8:1 single-bit data mux.
//            Grants one of 8 requesters for a tenure of at most MAX_HOLD
//            cycles, drives the registered select/grant, and registers the
//            selected data bit one cycle behind the select.
// Options  : MUXARB_LOCK_EN - when defined, lock=1 with the granted request
//            still high suppresses the MAX_HOLD timeout.
// Revision : 1.0 - initial release
// ============================================================================
module mux8_rr_arbiter #(
    parameter int MAX_HOLD = 4,
    parameter int HOLD_W   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       lock,
    input  logic [7:0] D,
    output logic [2:0] S,
    output logic [7:0] grant,
    output logic       gnt_vld,
    output logic       Y,
    output logic       Y_vld
);

    // Two-state controller: no tenure in progress, or a source owns the mux.
    localparam logic [0:0]        c_st_idle  = 1'b0;
    localparam logic [0:0]        c_st_grant = 1'b1;
    localparam logic [HOLD_W-1:0] c_max_hold = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] c_one      = HOLD_W'(1);

    logic [0:0]        r_state;
    logic [2:0]        r_ptr;
    logic [2:0]        r_sel;
    logic [7:0]        r_grant;
    logic              r_gnt_vld;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_y;
    logic              r_y_vld;

    logic [2:0]        w_base;
    logic [2:0]        w_idx;
    logic [2:0]        w_win;
    logic              w_found;
    logic              w_req_cur;
    logic              w_release;

`ifndef MUXARB_LOCK_EN
    // The lock input has no function in this build.
    logic w_unused_lock;
    assign w_unused_lock = lock;
`endif

    // Rotating priority search. In GRANT the search base is the post-release
    // pointer (S+1), which places the current holder at the lowest rank, so a
    // still-requesting holder only wins again when nobody else is asking.
    always_comb begin
        w_base  = (r_state == c_st_grant) ? (r_sel + 3'd1) : r_ptr;
        w_found = 1'b0;
        w_win   = w_base;
        w_idx   = w_base;
        // Walk from lowest to highest priority so the highest-priority hit
        // is the last one written.
        for (int i = 7; i >= 0; i--) begin
            w_idx = w_base + 3'(i);
            if (req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    // Tenure end: the holder withdrew, or its time slice is used up.
    always_comb begin
        w_req_cur = req[r_sel];
`ifdef MUXARB_LOCK_EN
        w_release = !w_req_cur || (!lock && (r_hold_cnt == c_max_hold));
`else
        w_release = !w_req_cur || (r_hold_cnt == c_max_hold);
`endif
    end

    // Arbitration state, pointer, select, grant and tenure counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_ptr      <= 3'd0;
            r_sel      <= 3'd0;
            r_grant    <= 8'd0;
            r_gnt_vld  <= 1'b0;
            r_hold_cnt <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_found) begin
                        r_grant    <= 8'd1 << w_win;
                        r_sel      <= w_win;
                        r_gnt_vld  <= 1'b1;
                        r_hold_cnt <= c_one;
                        r_state    <= c_st_grant;
                    end
                end
                c_st_grant: begin
                    if (w_release) begin
                        r_ptr <= r_sel + 3'd1;
                        if (w_found) begin
                            // Back-to-back handover, no idle bubble.
                            r_grant    <= 8'd1 << w_win;
                            r_sel      <= w_win;
                            r_hold_cnt <= c_one;
                        end else begin
                            // S keeps its last value while idle.
                            r_grant    <= 8'd0;
                            r_gnt_vld  <= 1'b0;
                            r_hold_cnt <= '0;
                            r_state    <= c_st_idle;
                        end
                    end else begin
                        // Saturate so a locked tenure cannot overflow.
                        r_hold_cnt <= (r_hold_cnt == c_max_hold) ? c_max_hold
                                                                 : r_hold_cnt + c_one;
                    end
                end
                default: begin
                    r_state    <= c_st_idle;
                    r_grant    <= 8'd0;
                    r_gnt_vld  <= 1'b0;
                    r_hold_cnt <= '0;
                end
            endcase
        end
    end

    // Registered mux output, one cycle behind the select.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_y     <= 1'b0;
            r_y_vld <= 1'b0;
        end else begin
            r_y     <= r_gnt_vld ? D[r_sel] : 1'b0;
            r_y_vld <= r_gnt_vld;
        end
    end

    assign S       = r_sel;
    assign grant   = r_grant;
    assign gnt_vld = r_gnt_vld;
    assign Y       = r_y;
    assign Y_vld   = r_y_vld;

endmodule
`default_nettype wire

// File: tb/tb_mux8_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux8_rr_arbiter
// Brief    : Directed self-checking bench for mux8_rr_arbiter (MAX_HOLD=4).
//            The lock scenario is compiled in when MUXARB_LOCK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux8_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       lock;
    logic [7:0] d_in;
    logic [2:0] s_out;
    logic [7:0] grant;
    logic       gnt_vld;
    logic       y_out;
    logic       y_vld;

    int n_checks;
    int n_fail;

    mux8_rr_arbiter #(
        .MAX_HOLD (4),
        .HOLD_W   (3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .lock    (lock),
        .D       (d_in),
        .S       (s_out),
        .grant   (grant),
        .gnt_vld (gnt_vld),
        .Y       (y_out),
        .Y_vld   (y_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One active edge, then settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int src;
        int prev;
        n_checks = 0;
        n_fail   = 0;
        rst  = 1'b1;
        req  = 8'h00;
        lock = 1'b0;
        d_in = 8'h00;

        // Reset state.
        do_reset();
        check("rst_grant", 32'(grant), 32'h00);
        check("rst_S", 32'(s_out), 32'd0);
        check("rst_vld", 32'(gnt_vld), 32'd0);
        check("rst_Y", 32'(y_out), 32'd0);
        check("rst_Yvld", 32'(y_vld), 32'd0);

        // Idle with no requests for 5 cycles.
        for (int k = 0; k < 5; k++) begin
            tick();
            check("idle_grant", 32'(grant), 32'h00);
            check("idle_vld", 32'(gnt_vld), 32'd0);
            check("idle_S", 32'(s_out), 32'd0);
            check("idle_Yvld", 32'(y_vld), 32'd0);
        end

        // All request: 0..7,0 in turn, 4 cycles each, Y = D[prev S].
        do_reset();
        req  = 8'hFF;
        d_in = 8'h55;
        for (int k = 0; k < 36; k++) begin
            tick();
            src = (k / 4) % 8;
            check("rr_grant", 32'(grant), 32'h1 << src);
            check("rr_S", 32'(s_out), 32'(src));
            check("rr_vld", 32'(gnt_vld), 32'd1);
            if (k == 0) begin
                check("rr_Y0", 32'(y_out), 32'd0);
                check("rr_Yvld0", 32'(y_vld), 32'd0);
            end else begin
                prev = ((k - 1) / 4) % 8;
                check("rr_Y", 32'(y_out), 32'(d_in[prev]));
                check("rr_Yvld", 32'(y_vld), 32'd1);
            end
        end

        // req=24: source 2 drops after 2 cycles, handover to 5.
        do_reset();
        req  = 8'h24;
        d_in = 8'h20;
        tick();
        check("x24_g1", 32'(grant), 32'h04);
        check("x24_S1", 32'(s_out), 32'd2);
        tick();
        check("x24_g2", 32'(grant), 32'h04);
        req = 8'h20;
        tick();
        check("x24_g3", 32'(grant), 32'h20);
        check("x24_S3", 32'(s_out), 32'd5);
        check("x24_Y3", 32'(y_out), 32'd0);
        tick();
        check("x24_Y4", 32'(y_out), 32'd1);
        check("x24_Yvld4", 32'(y_vld), 32'd1);

        // Source 7 timeout with req=81: wrap to 0, then back to 7.
        do_reset();
        req = 8'h80;
        tick();
        check("wrap_g7a", 32'(grant), 32'h80);
        req = 8'h81;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("wrap_hold7", 32'(grant), 32'h80);
        end
        tick();
        check("wrap_g0", 32'(grant), 32'h01);
        check("wrap_S0", 32'(s_out), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("wrap_hold0", 32'(grant), 32'h01);
        end
        tick();
        check("wrap_g7b", 32'(grant), 32'h80);
        check("wrap_S7b", 32'(s_out), 32'd7);

        // Reset mid-tenure on source 3 (pointer was 1 at that time).
        do_reset();
        req = 8'h01;
        tick();
        check("mr_g0", 32'(grant), 32'h01);
        req = 8'h08;
        tick();
        check("mr_g3", 32'(grant), 32'h08);
        tick();
        check("mr_g3b", 32'(grant), 32'h08);
        rst = 1'b1;
        tick();
        check("mr_rst_grant", 32'(grant), 32'h00);
        check("mr_rst_vld", 32'(gnt_vld), 32'd0);
        check("mr_rst_S", 32'(s_out), 32'd0);
        check("mr_rst_Yvld", 32'(y_vld), 32'd0);
        rst = 1'b0;
        req = 8'h09;
        tick();
        check("mr_after_grant", 32'(grant), 32'h01);
        check("mr_after_S", 32'(s_out), 32'd0);

        // Full release to idle: S holds last value.
        req = 8'h00;
        tick();
        check("rel_grant", 32'(grant), 32'h00);
        check("rel_vld", 32'(gnt_vld), 32'd0);
        check("rel_S", 32'(s_out), 32'd0);

`ifdef MUXARB_LOCK_EN
        // Lock holds source 0 beyond MAX_HOLD, release when lock drops.
        do_reset();
        lock = 1'b1;
        req  = 8'h03;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("lock_hold", 32'(grant), 32'h01);
        end
        lock = 1'b0;
        tick();
        check("lock_rel", 32'(grant), 32'h02);
        check("lock_rel_S", 32'(s_out), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
